// File: rtl/aes_key_expand_seq.sv
// Iterative AES-128 key schedule: one registered round key per 'next' pulse, 1-cycle latency.
// No backpressure; start restarts from key_in at any time and beats a simultaneous next.
module aes_key_expand_seq #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         next,
  output logic [127:0] round_key,
  output logic [3:0]   round_num,
  output logic         key_valid,
  output logic         last_key,
  output logic         busy
);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_e;

  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

  state_e       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   num_q, num_d;
  logic         valid_q, valid_d;
  logic         last_q, last_d;
  logic [127:0] key_nxt;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box as x^254 in GF(2^8) (0 maps to 0) followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] rc;
    case (idx)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h0};
    n0 = k[127:96] ^ t;
    n1 = k[95:64]  ^ n0;
    n2 = k[63:32]  ^ n1;
    n3 = k[31:0]   ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  assign key_nxt = key_step(key_q, rcon(num_q + 4'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      key_q   <= '0;
      num_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      num_q   <= num_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    num_d   = num_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (start) begin
      state_d = ACTIVE;
      key_d   = key_in;
      num_d   = 4'd0;
      valid_d = 1'b1;
      last_d  = 1'b0;
    end else if (state_q == ACTIVE && next) begin
      if (num_q < LAST_RND) begin
        key_d  = key_nxt;
        num_d  = num_q + 4'd1;
        last_d = ((num_q + 4'd1) == LAST_RND);
      end else begin
        // Past the final key: drop valid but keep key/round visible.
        state_d = IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    end
  end

  always_comb begin
    round_key = key_q;
    round_num = num_q;
    key_valid = valid_q;
    last_key  = last_q;
    busy      = (state_q == ACTIVE);
  end

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Self-checking bench for aes_key_expand_seq: FIPS-197 vector table, corner sequences,
// and random keys against a word-oriented key expansion model.
module tb_aes_key_expand_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in;
  logic         nxt;
  logic [127:0] round_key, round_key3;
  logic [3:0]   round_num, round_num3;
  logic         key_valid, key_valid3;
  logic         last_key, last_key3;
  logic         busy, busy3;

  int checks = 0;
  int errors = 0;

  logic [7:0]   sbox_t [256];
  logic [127:0] rk [0:10];

  always #5 clk = ~clk;

  aes_key_expand_seq #(.NUM_ROUNDS(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in), .next(nxt),
    .round_key(round_key), .round_num(round_num), .key_valid(key_valid),
    .last_key(last_key), .busy(busy)
  );

  aes_key_expand_seq #(.NUM_ROUNDS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in), .next(nxt),
    .round_key(round_key3), .round_num(round_num3), .key_valid(key_valid3),
    .last_key(last_key3), .busy(busy3)
  );

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    while (y != 0) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box from first principles: search for the multiplicative inverse, then affine map.
  task automatic build_sbox();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_t[x] = s;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  // FIPS-197 KeyExpansion over 44 words, sliced into 11 round keys.
  task automatic expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] tmp;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = xtime(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_start(input logic [127:0] key);
    key_in = key;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic adv(input int gap);
    repeat (gap) @(negedge clk);
    nxt = 1'b1;
    @(negedge clk);
    nxt = 1'b0;
  endtask

  typedef struct {
    logic [127:0] key;
    int           rnd;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [6];

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  initial begin
    vecs[0] = '{FIPS_KEY, 0,  FIPS_KEY};
    vecs[1] = '{FIPS_KEY, 1,  128'ha0fafe1788542cb123a339392a6c7605};
    vecs[2] = '{FIPS_KEY, 2,  128'hf2c295f27a96b9435935807a7359f67f};
    vecs[3] = '{FIPS_KEY, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[4] = '{128'h0,   1,  128'h62636363626363636263636362636363};
    vecs[5] = '{128'h0,   10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};

    rst_n  = 1'b0;
    start  = 1'b0;
    nxt    = 1'b0;
    key_in = '0;
    build_sbox();
    repeat (2) @(negedge clk);
    chk("rst_key", round_key, 0);
    chk("rst_num", round_num, 0);
    chk("rst_valid", key_valid, 0);
    chk("rst_last", last_key, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Known-answer table
    for (int v = 0; v < 6; v++) begin
      do_start(vecs[v].key);
      for (int r = 0; r < vecs[v].rnd; r++) adv($urandom_range(0, 5));
      chk($sformatf("vec%0d_key", v), round_key, vecs[v].exp);
      chk($sformatf("vec%0d_num", v), round_num, 128'(vecs[v].rnd));
      chk($sformatf("vec%0d_valid", v), key_valid, 1);
      chk($sformatf("vec%0d_last", v), last_key, 128'(vecs[v].rnd == 10));
    end

    // One next beyond round 10 (the schedule above ended on round 10)
    adv(0);
    chk("end_valid", key_valid, 0);
    chk("end_busy", busy, 0);
    chk("end_last", last_key, 0);
    chk("end_key_held", round_key, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    chk("end_num_held", round_num, 10);

    // Restart mid-schedule with start and next in the same cycle
    expand(FIPS_KEY);
    do_start(128'h0);
    for (int r = 0; r < 4; r++) adv($urandom_range(0, 2));
    key_in = FIPS_KEY;
    start  = 1'b1;
    nxt    = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    nxt    = 1'b0;
    chk("restart_num", round_num, 0);
    chk("restart_key", round_key, FIPS_KEY);
    chk("restart_valid", key_valid, 1);
    key_in = 128'hdeadbeef_01234567_89abcdef_cafef00d;
    adv(1);
    chk("restart_r1", round_key, rk[1]);

    // Asynchronous reset at round 6, then next pulses in IDLE
    for (int r = 1; r < 6; r++) adv(0);
    chk("pre_rst_r6", round_key, rk[6]);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_key", round_key, 0);
    chk("arst_num", round_num, 0);
    chk("arst_valid", key_valid, 0);
    chk("arst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    adv(0);
    adv(2);
    chk("idle_next_key", round_key, 0);
    chk("idle_next_num", round_num, 0);
    chk("idle_next_valid", key_valid, 0);
    do_start(FIPS_KEY);
    adv(0);
    chk("post_rst_r1", round_key, rk[1]);
    chk("post_rst_num", round_num, 1);

    // NUM_ROUNDS=3 instance
    do_start(FIPS_KEY);
    adv(0);
    adv(3);
    chk("n3_r2_last", last_key3, 0);
    adv(1);
    chk("n3_r3_key", round_key3, rk[3]);
    chk("n3_r3_num", round_num3, 3);
    chk("n3_r3_last", last_key3, 1);
    chk("n3_r3_busy", busy3, 1);
    adv(0);
    chk("n3_end_valid", key_valid3, 0);
    chk("n3_end_busy", busy3, 0);
    chk("n3_end_key", round_key3, rk[3]);

    // Random keys against the reference expansion
    for (int k = 0; k < 5; k++) begin
      logic [127:0] key;
      key = {$urandom, $urandom, $urandom, $urandom};
      expand(key);
      do_start(key);
      key_in = {$urandom, $urandom, $urandom, $urandom};
      chk($sformatf("rnd%0d_r0", k), round_key, rk[0]);
      for (int r = 1; r <= 10; r++) begin
        adv($urandom_range(0, 5));
        chk($sformatf("rnd%0d_r%0d_key", k, r), round_key, rk[r]);
        chk($sformatf("rnd%0d_r%0d_num", k, r), round_num, 128'(r));
        chk($sformatf("rnd%0d_r%0d_last", k, r), last_key, 128'(r == 10));
      end
      adv($urandom_range(0, 3));
      chk($sformatf("rnd%0d_done", k), key_valid, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
